// File: rtl/uart_rx_frame_if.sv
// UART receive-side bundle: serial line, per-frame configuration and the result strobes.
// The line side (master) drives RX_IN and configuration; the receiver (slave) drives the results.
// No handshake: results are single-cycle pulses that the consumer must take when presented.
interface uart_rx_frame_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
);
  logic                      RX_IN;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [DATA_WIDTH-1:0]     RX_p_data;
  logic                      RX_d_valid;
  logic                      Par_err;
  logic                      Stp_err;

  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP,
    input  RX_p_data, RX_d_valid, Par_err, Stp_err
  );

  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP,
    output RX_p_data, RX_d_valid, Par_err, Stp_err
  );
endinterface

// File: rtl/uart_rx_frame.sv
// UART frame receiver: start, DATA_WIDTH data bits LSB first, optional parity, one stop bit; 3-sample majority per bit.
// Latency: result pulse about 2 + (DATA_WIDTH+1+PAR_EN)*P + P/2 + 2 clocks after the start edge on RX_IN.
// No backpressure: RX_d_valid / Par_err / Stp_err are one-cycle pulses; RX_p_data holds the last good byte.
module uart_rx_frame #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic           CLK,
  input  logic           RST,
  uart_rx_frame_if.slave rx_if
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_WAIT_HI = 3'd5;

  localparam int BW = $clog2(DATA_WIDTH + 1);

  logic                      r_sync1;
  logic                      r_rx_s;
  logic [2:0]                r_state;
  logic [PRESCALE_WIDTH-1:0] r_p;
  logic                      r_par_en;
  logic                      r_par_typ;
  logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
  logic [BW-1:0]             r_bit_cnt;
  logic [DATA_WIDTH-1:0]     r_shift;
  logic [DATA_WIDTH-1:0]     r_data;
  logic                      r_s0;
  logic                      r_s1;
  logic                      r_bit;
  logic                      r_perr_flag;
  logic                      r_valid;
  logic                      r_par_err;
  logic                      r_stp_err;

  logic [PRESCALE_WIDTH-1:0] w_half;
  logic [PRESCALE_WIDTH-1:0] w_p_in;
  logic [PRESCALE_WIDTH-1:0] w_edge_nxt;
  logic                      w_at_smp0;
  logic                      w_at_smp1;
  logic                      w_at_smp2;
  logic                      w_at_dec;
  logic                      w_at_last;
  logic                      w_vote;
  logic                      w_exp_par;

  // Prescale values below 8 leave no room for the three mid-bit samples, so they run as 8.
  assign w_p_in     = (rx_if.Prescale < PRESCALE_WIDTH'(8)) ? PRESCALE_WIDTH'(8) : rx_if.Prescale;
  assign w_half     = r_p >> 1;
  assign w_at_smp0  = (r_edge_cnt == w_half - PRESCALE_WIDTH'(2));
  assign w_at_smp1  = (r_edge_cnt == w_half - PRESCALE_WIDTH'(1));
  assign w_at_smp2  = (r_edge_cnt == w_half);
  assign w_at_dec   = (r_edge_cnt == w_half + PRESCALE_WIDTH'(1));
  assign w_at_last  = (r_edge_cnt == r_p - PRESCALE_WIDTH'(1));
  assign w_edge_nxt = w_at_last ? '0 : r_edge_cnt + PRESCALE_WIDTH'(1);
  assign w_vote     = (r_s0 & r_s1) | (r_s0 & r_rx_s) | (r_s1 & r_rx_s);
  assign w_exp_par  = (^r_shift) ^ r_par_typ;

  assign rx_if.RX_p_data  = r_data;
  assign rx_if.RX_d_valid = r_valid;
  assign rx_if.Par_err    = r_par_err;
  assign rx_if.Stp_err    = r_stp_err;

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= rx_if.RX_IN;
      r_rx_s  <= r_sync1;
    end
  end

  // Take three samples around mid-bit; the majority is registered one cycle later as the bit decision.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s0  <= 1'b0;
      r_s1  <= 1'b0;
      r_bit <= 1'b0;
    end else begin
      if (w_at_smp0) r_s0  <= r_rx_s;
      if (w_at_smp1) r_s1  <= r_rx_s;
      if (w_at_smp2) r_bit <= w_vote;
    end
  end

  // Frame FSM: bit timing, data shifting, parity tracking and the one-cycle result pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_p         <= PRESCALE_WIDTH'(8);
      r_par_en    <= 1'b0;
      r_par_typ   <= 1'b0;
      r_edge_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_perr_flag <= 1'b0;
      r_valid     <= 1'b0;
      r_par_err   <= 1'b0;
      r_stp_err   <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_par_err <= 1'b0;
      r_stp_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_edge_cnt <= '0;
          if (!r_rx_s) begin
            // Configuration is frozen for the whole frame at the start edge.
            r_state     <= S_START;
            r_p         <= w_p_in;
            r_par_en    <= rx_if.PAR_EN;
            r_par_typ   <= rx_if.PAR_TYP;
            r_perr_flag <= 1'b0;
          end
        end
        S_START: begin
          if (w_at_dec && r_bit) begin
            // Start bit did not hold low through mid-bit: treat as a glitch.
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
          end else if (w_at_last) begin
            r_state    <= S_DATA;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
          end else begin
            r_edge_cnt <= w_edge_nxt;
          end
        end
        S_DATA: begin
          r_edge_cnt <= w_edge_nxt;
          if (w_at_dec) begin
            r_shift   <= {r_bit, r_shift[DATA_WIDTH-1:1]};
            r_bit_cnt <= r_bit_cnt + BW'(1);
          end
          if (w_at_last && (r_bit_cnt == BW'(DATA_WIDTH))) begin
            r_state <= r_par_en ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          r_edge_cnt <= w_edge_nxt;
          if (w_at_dec && (r_bit != w_exp_par)) r_perr_flag <= 1'b1;
          if (w_at_last) r_state <= S_STOP;
        end
        S_STOP: begin
          r_edge_cnt <= w_edge_nxt;
          // Resolve at mid stop bit so a start edge at the nominal stop end is still seen in IDLE.
          if (w_at_dec) begin
            r_edge_cnt <= '0;
            if (!r_bit) begin
              r_stp_err <= 1'b1;
              r_state   <= S_WAIT_HI;
            end else if (r_perr_flag) begin
              r_par_err <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        S_WAIT_HI: begin
          // A held-low line must return high before another frame can start.
          r_edge_cnt <= '0;
          if (r_rx_s) r_state <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_edge_cnt <= '0;
        end
      endcase
    end
  end

endmodule
